// File: rtl/feb_push_sched_if.sv
// Bundle of push/grant/status signals between the push-delay chain and the scheduler.
interface feb_push_sched_if #(
    parameter int unsigned NCH   = 6,
    parameter int unsigned TMO_W = 8
);
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   mask;
    logic             done;
    logic             clr_err;
    logic [TMO_W-1:0] tmo_limit;
    logic [NCH-1:0]   gnt;
    logic             gnt_vld;
    logic             busy;
    logic             pend_any;
    logic [NCH-1:0]   ovfl;
    logic             tmo_err;

    modport master (
        output push, mask, done, clr_err, tmo_limit,
        input  gnt, gnt_vld, busy, pend_any, ovfl, tmo_err
    );

    modport slave (
        input  push, mask, done, clr_err, tmo_limit,
        output gnt, gnt_vld, busy, pend_any, ovfl, tmo_err
    );
endinterface

// File: rtl/feb_push_sched.sv
// Round-robin readout scheduler for per-FEB push pulses with pending counters.
// Grant timeout logic is built only when FEB_PUSH_SCHED_TIMEOUT_EN is defined.
module feb_push_sched #(
    parameter int unsigned NCH   = 6,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TMO_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    feb_push_sched_if.slave    io_bus
);
    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [CNT_W-1:0] w_cnt_d [NCH];
    logic [PTR_W-1:0] r_ptr, w_ptr_d;
    logic [NCH-1:0]   r_gnt, w_gnt_d;
    logic [NCH-1:0]   r_ovfl, w_ovfl_d;
    logic             r_tmo_err, w_tmo_err_d;
    logic [NCH-1:0]   w_elig;
    logic             w_win_vld;
    logic [PTR_W-1:0] w_win;
    logic             w_issue;
    logic             w_tmo_hit;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_elig[i] = (r_cnt[i] != '0) && !io_bus.mask[i];
        end
    end

    // Scan farthest-to-nearest from the pointer so the nearest eligible channel wins.
    always_comb begin
        int idx;
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int off = NCH; off >= 1; off--) begin
            idx = int'(r_ptr) + off;
            if (idx >= int'(NCH)) idx = idx - int'(NCH);
            if (w_elig[idx]) begin
                w_win_vld = 1'b1;
                w_win     = PTR_W'(idx);
            end
        end
    end

`ifdef FEB_PUSH_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmr, w_tmr_d;

    assign w_tmo_hit = (io_bus.tmo_limit != '0) &&
                       (({1'b0, r_tmr} + (TMO_W+1)'(1)) == {1'b0, io_bus.tmo_limit});

    always_comb begin
        w_tmr_d = r_tmr;
        if (r_state == StIdle && w_win_vld) begin
            w_tmr_d = '0;
        end else if (r_state == StActive && !io_bus.done && r_tmr != '1) begin
            w_tmr_d = r_tmr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_tmr <= '0;
        else       r_tmr <= w_tmr_d;
    end
`else
    logic w_unused_tmo_limit;
    assign w_unused_tmo_limit = ^io_bus.tmo_limit;
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_gnt_d     = r_gnt;
        w_ptr_d     = r_ptr;
        w_issue     = 1'b0;
        w_tmo_err_d = r_tmo_err & ~io_bus.clr_err;
        unique case (r_state)
            StIdle: begin
                if (w_win_vld) begin
                    w_issue   = 1'b1;
                    w_gnt_d   = NCH'(1) << w_win;
                    w_ptr_d   = w_win;
                    w_state_d = StActive;
                end
            end
            StActive: begin
                // DONE takes precedence over a coincident timeout.
                if (io_bus.done) begin
                    w_gnt_d   = '0;
                    w_state_d = StGap;
                end else if (w_tmo_hit) begin
                    w_tmo_err_d = 1'b1;
                    w_gnt_d     = '0;
                    w_state_d   = StGap;
                end
            end
            StGap:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        logic inc;
        logic dec;
        for (int i = 0; i < NCH; i++) begin
            inc         = io_bus.push[i] && !io_bus.mask[i];
            dec         = w_issue && (w_win == PTR_W'(i));
            w_cnt_d[i]  = r_cnt[i];
            w_ovfl_d[i] = r_ovfl[i] & ~io_bus.clr_err;
            if (inc && !dec) begin
                if (r_cnt[i] == CNT_MAX) w_ovfl_d[i] = 1'b1;
                else                     w_cnt_d[i]  = r_cnt[i] + 1'b1;
            end else if (dec && !inc) begin
                w_cnt_d[i] = r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_ptr     <= PTR_W'(NCH - 1);
            r_ovfl    <= '0;
            r_tmo_err <= 1'b0;
            for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
        end else begin
            r_state   <= w_state_d;
            r_gnt     <= w_gnt_d;
            r_ptr     <= w_ptr_d;
            r_ovfl    <= w_ovfl_d;
            r_tmo_err <= w_tmo_err_d;
            for (int i = 0; i < NCH; i++) r_cnt[i] <= w_cnt_d[i];
        end
    end

    assign io_bus.gnt      = r_gnt;
    assign io_bus.gnt_vld  = (r_state == StActive);
    assign io_bus.busy     = (r_state == StActive) || (r_state == StGap);
    assign io_bus.pend_any = |w_elig;
    assign io_bus.ovfl     = r_ovfl;
`ifdef FEB_PUSH_SCHED_TIMEOUT_EN
    assign io_bus.tmo_err  = r_tmo_err;
`else
    assign io_bus.tmo_err  = 1'b0;
`endif
endmodule

// File: tb/tb_feb_push_sched.sv
// Scoreboard bench for feb_push_sched: a queue-based reference model predicts grants,
// an independent monitor checks every observed grant against the prediction queue.
module tb_feb_push_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    feb_push_sched_if #(.NCH(6), .TMO_W(8)) bus ();

    feb_push_sched #(.NCH(6), .CNT_W(4), .TMO_W(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_cnt [6];
    int         m_ptr;
    int         m_phase;     // 0 idle, 1 granted, 2 gap
    int         m_act;
    bit [5:0]   m_ovfl;
    bit         m_tmo;
    logic [5:0] exp_q [$];
    logic [7:0] tmo_lim;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [5:0] p, input logic [5:0] m, input logic d,
                              input logic c, input logic r);
        int         win;
        int         ch;
        bit [5:0]   ovset;
        bit         tset;
        logic [5:0] one;
        bit         inc;
        bit         dec;
        if (r) begin
            for (int i = 0; i < 6; i++) m_cnt[i] = 0;
            m_ptr = 5; m_phase = 0; m_act = 0; m_ovfl = '0; m_tmo = 1'b0;
            return;
        end
        win = -1; ovset = '0; tset = 1'b0; one = 6'b000001;
        case (m_phase)
            0: begin
                for (int k = 1; k <= 6; k++) begin
                    ch = (m_ptr + k) % 6;
                    if (win < 0 && m_cnt[ch] > 0 && !m[ch]) win = ch;
                end
                if (win >= 0) begin
                    m_phase = 1; m_ptr = win; m_act = 0;
                    exp_q.push_back(one << win);
                end
            end
            1: begin
                if (d) m_phase = 2;
                else begin
`ifdef FEB_PUSH_SCHED_TIMEOUT_EN
                    m_act++;
                    if (tmo_lim != 0 && m_act == int'(tmo_lim)) begin
                        tset = 1'b1; m_phase = 2;
                    end
`endif
                end
            end
            default: m_phase = 0;
        endcase
        for (int i = 0; i < 6; i++) begin
            inc = p[i] && !m[i];
            dec = (i == win);
            if (inc && !dec) begin
                if (m_cnt[i] == 15) ovset[i] = 1'b1;
                else                m_cnt[i]++;
            end else if (dec && !inc) begin
                m_cnt[i]--;
            end
        end
        m_ovfl = (c ? 6'b0 : m_ovfl) | ovset;
        m_tmo  = (c ? 1'b0 : m_tmo) | tset;
    endtask

    function automatic logic model_pend(input logic [5:0] m);
        logic any = 1'b0;
        for (int i = 0; i < 6; i++) if (m_cnt[i] > 0 && !m[i]) any = 1'b1;
        return any;
    endfunction

    task automatic cycle(input logic [5:0] p, input logic [5:0] m, input logic d,
                         input logic c, input logic r);
        @(negedge clk);
        bus.push = p; bus.mask = m; bus.done = d; bus.clr_err = c; bus.tmo_limit = tmo_lim;
        rst = r;
        model_step(p, m, d, c, r);
        @(posedge clk);
        #1;
        chk("pend_any", 32'(bus.pend_any), 32'(model_pend(m)));
        chk("busy",     32'(bus.busy),     32'(m_phase != 0));
        chk("gnt_vld",  32'(bus.gnt_vld),  32'(m_phase == 1));
        chk("ovfl",     32'(bus.ovfl),     32'(m_ovfl));
        chk("tmo_err",  32'(bus.tmo_err),  32'(m_tmo));
    endtask

    // Monitor: every fresh grant must match the oldest predicted grant.
    logic [5:0] mon_prev = '0;
    always @(negedge clk) begin
        if (bus.gnt !== 6'b0 && mon_prev === 6'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL grant_unexpected: got %0h expected none", bus.gnt);
            end else begin
                chk("grant", 32'(bus.gnt), 32'(exp_q.pop_front()));
            end
            chk("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
        end
        mon_prev = bus.gnt;
    end

    logic [5:0] rp, rm;
    logic       rd, rc, rr;

    initial begin
        tmo_lim = 8'd0;
        bus.push = '0; bus.mask = '0; bus.done = 1'b0; bus.clr_err = 1'b0;
        bus.tmo_limit = '0;
        cycle(6'h00, 6'h00, 0, 0, 1);
        cycle(6'h00, 6'h00, 0, 0, 1);
        chk("reset_gnt", 32'(bus.gnt), 32'd0);

        // Single push on ch0, grant two edges later, then DONE
        cycle(6'b000001, 6'h00, 0, 0, 0);
        chk("s1_no_gnt_yet", 32'(bus.gnt), 32'd0);
        cycle(6'h00, 6'h00, 0, 0, 0);
        chk("s1_gnt", 32'(bus.gnt), 32'b000001);
        repeat (3) cycle(6'h00, 6'h00, 0, 0, 0);
        cycle(6'h00, 6'h00, 1, 0, 0);
        chk("s1_gnt_dropped", 32'(bus.gnt), 32'd0);
        cycle(6'h00, 6'h00, 0, 0, 0);
        chk("s1_pend_any", 32'(bus.pend_any), 32'd0);

        // All channels at once, DONE one cycle after each grant
        cycle(6'b111111, 6'h00, 0, 0, 0);
        repeat (24) cycle(6'h00, 6'h00, bus.gnt_vld, 0, 0);
        chk("s2_no_ovfl", 32'(bus.ovfl), 32'd0);

        // ch2 held high with a stuck consumer: saturation and overflow
        repeat (20) cycle(6'b000100, 6'h00, 0, 0, 0);
        chk("s3_ovfl", 32'(bus.ovfl), 32'b000100);
        cycle(6'h00, 6'h00, 0, 1, 0);
        chk("s3_ovfl_clr", 32'(bus.ovfl), 32'd0);
        repeat (60) cycle(6'h00, 6'h00, bus.gnt_vld, 0, 0);
        chk("s3_drained", 32'(bus.pend_any), 32'd0);

        // Timeout on ch4
        tmo_lim = 8'd10;
        cycle(6'b010000, 6'h00, 0, 0, 0);
        repeat (13) cycle(6'h00, 6'h00, 0, 0, 0);
`ifdef FEB_PUSH_SCHED_TIMEOUT_EN
        chk("s4_tmo_err", 32'(bus.tmo_err), 32'd1);
        chk("s4_gnt_off", 32'(bus.gnt), 32'd0);
`else
        chk("s4_gnt_held", 32'(bus.gnt), 32'b010000);
`endif
        cycle(6'h00, 6'h00, 0, 1, 0);
        chk("s4_tmo_clr", 32'(bus.tmo_err), 32'd0);
        cycle(6'h00, 6'h00, bus.gnt_vld, 0, 0);
        repeat (3) cycle(6'h00, 6'h00, 0, 0, 0);
        tmo_lim = 8'd0;

        // Masking: ch1 retained while ch3 is served
        cycle(6'b001010, 6'h00, 0, 0, 0);
        cycle(6'h00, 6'b000010, 0, 0, 0);
        chk("s5_gnt_ch3", 32'(bus.gnt), 32'b001000);
        repeat (6) cycle(6'h00, 6'b000010, bus.gnt_vld, 0, 0);
        chk("s5_ch1_masked", 32'(bus.pend_any), 32'd0);
        cycle(6'h00, 6'h00, 0, 0, 0);
        chk("s5_gnt_ch1", 32'(bus.gnt), 32'b000010);
        repeat (4) cycle(6'h00, 6'h00, bus.gnt_vld, 0, 0);

        // Reset mid-grant with 3 pending on ch5
        repeat (4) cycle(6'b100000, 6'h00, 0, 0, 0);
        cycle(6'h00, 6'h00, 0, 0, 1);
        chk("s6_gnt", 32'(bus.gnt), 32'd0);
        chk("s6_pend", 32'(bus.pend_any), 32'd0);
        repeat (5) cycle(6'h00, 6'h00, 0, 0, 0);
        chk("s6_idle", 32'(bus.gnt_vld), 32'd0);

        // Randomized traffic
        rm = '0;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       tmo_lim = 8'd0;
                    1:       tmo_lim = 8'd5;
                    default: tmo_lim = 8'(8 + $urandom_range(0, 8));
                endcase
            end
            rp = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
            if ($urandom_range(0, 15) == 0) rm = 6'($urandom) & 6'($urandom);
            rd = bus.gnt_vld && ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 15) == 0);
            rr = ($urandom_range(0, 199) == 0);
            cycle(rp, rm, rd, rc, rr);
        end
        repeat (3) cycle(6'h00, 6'h00, 0, 0, 0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
